serial_addsub: RTL and testbench

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair DIGIT bits per clock, least-significant digit first. It produces the sum, carry-out and signed-overflow flag behind a valid/ready handshake on both sides. It is the sequential, width-generic successor to the team's single-bit full adder. It sits between an operand source and a result consumer in datapaths where area matters more than latency.

---
 rtl/addsub_pkg.sv | 21 ++
 rtl/digit_adder.sv | 29 ++
 rtl/serial_addsub.sv | 125 ++++++++++++
 tb/tb_serial_addsub.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM states,
// counter sizing and the configuration legality test.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Digit counter width: ceil(log2(n)), never less than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // A configuration is usable when WIDTH >= 2 and DIGIT evenly divides WIDTH.
   function automatic bit cfg_ok(input int width, input int digit);
      return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
   endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder. c_msb is the carry into the top bit
// of the digit, which on the last digit is the carry into the operand MSB.
module digit_adder #(
   parameter int DIGIT = 2
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic             ci,
   output logic [DIGIT-1:0] s_d,
   output logic             co,
   output logic             c_msb
);

   // Ripple the carry through the digit one bit at a time.
   always_comb begin
      logic [DIGIT:0] c;
      // NOTE: every output gets a value on every pass through the block, so no latch can be inferred.
      c     = '0;
      s_d   = '0;
      c[0]  = ci;
      for (int i = 0; i < DIGIT; i++) begin
         s_d[i]  = a_d[i] ^ b_d[i] ^ c[i];
         c[i+1]  = (a_d[i] & b_d[i]) | (a_d[i] & c[i]) | (b_d[i] & c[i]);
      end
      co    = c[DIGIT];
      c_msb = c[DIGIT-1];
   end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: a WIDTH-bit operand pair is added DIGIT bits
// per clock, LSB digit first, behind valid/ready handshakes on both sides.
module serial_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int            N    = WIDTH / DIGIT;
   localparam int            CW   = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if (!cfg_ok(WIDTH, DIGIT)) begin : g_cfg_err
      $error("serial_addsub: WIDTH must be >= 2 and an exact multiple of DIGIT");
   end

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q;       // operand A, refilled from the top with result digits
   logic [WIDTH-1:0] b_q;       // operand B (already inverted for subtract)
   logic             c_q;       // carry between digits
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;
   logic             in_ready_q;
   logic             out_valid_q;

   logic [DIGIT-1:0] s_d;
   logic             co;
   logic             c_msb;
   logic [WIDTH-1:0] acc_d;

   digit_adder #(.DIGIT(DIGIT)) u_digit (
      .a_d   (a_q[DIGIT-1:0]),
      .b_d   (b_q[DIGIT-1:0]),
      .ci    (c_q),
      .s_d   (s_d),
      .co    (co),
      .c_msb (c_msb)
   );

   // Shift A one digit right and drop the fresh result digit in at the top;
   // after N digits the register holds the complete result.
   always_comb begin
      acc_d = (a_q >> DIGIT) | (WIDTH'(s_d) << (WIDTH - DIGIT));
   end

   // Control FSM plus operand, carry and result registers.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: datapath registers are reset too, because the result outputs have defined reset values.
         state_q     <= IDLE;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  a_q        <= a;
                  b_q        <= sub ? ~b : b;
                  c_q        <= cin ^ sub;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               a_q <= acc_d;
               b_q <= b_q >> DIGIT;
               c_q <= co;
               if (cnt_q == LAST) begin
                  cnt_q       <= '0;
                  sum_q       <= acc_d;
                  cout_q      <= co;
                  ovf_q       <= co ^ c_msb;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: directed WIDTH=8/DIGIT=2 scenarios with literal
// expectations, plus exhaustive WIDTH=4 runs at DIGIT=1 and DIGIT=4, all
// scored against an arithmetic model.
module tb_serial_addsub;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- model ----------------
   typedef struct packed {
      logic       cout;
      logic       ovf;
      logic [7:0] sum;
   } res_t;

   typedef struct {
      res_t r;
      int   cyc;
   } exp_t;

   // Plain integer arithmetic: unsigned result for sum/carry, signed result for overflow.
   function automatic res_t model(input int w, input int a, input int b, input bit cin, input bit sub);
      int   m, sa, sb, u, s;
      res_t r;
      m  = 1 << w;
      sa = (a >= m / 2) ? a - m : a;
      sb = (b >= m / 2) ? b - m : b;
      if (!sub) begin
         u      = a + b + int'(cin);
         s      = sa + sb + int'(cin);
         r.cout = (u >= m);
      end else begin
         u      = a - b - int'(cin);
         s      = sa - sb - int'(cin);
         r.cout = (u >= 0);
      end
      r.sum = 8'(((u % m) + m) % m);
      r.ovf = (s < -(m / 2)) || (s > (m / 2) - 1);
      return r;
   endfunction

   // ---------------- DUTs ----------------
   logic       rst8_n = 1'b0, rst_n = 1'b0;
   logic       iv8 = 0, ir8, cin8 = 0, sub8 = 0, ov8, or8 = 1, cout8, ovf8;
   logic [7:0] a8 = 0, b8 = 0, sum8;
   logic       iv41 = 0, ir41, cin41 = 0, sub41 = 0, ov41, or41 = 1, cout41, ovf41;
   logic [3:0] a41 = 0, b41 = 0, sum41;
   logic       iv44 = 0, ir44, cin44 = 0, sub44 = 0, ov44, or44 = 1, cout44, ovf44;
   logic [3:0] a44 = 0, b44 = 0, sum44;

   serial_addsub #(.WIDTH(8), .DIGIT(2)) u_d8 (
      .clk(clk), .rst_n(rst8_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(sum8),
      .cout(cout8), .ovf(ovf8));

   serial_addsub #(.WIDTH(4), .DIGIT(1)) u_d41 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv41), .in_ready(ir41), .a(a41), .b(b41),
      .cin(cin41), .sub(sub41), .out_valid(ov41), .out_ready(or41), .sum(sum41),
      .cout(cout41), .ovf(ovf41));

   serial_addsub #(.WIDTH(4), .DIGIT(4)) u_d44 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv44), .in_ready(ir44), .a(a44), .b(b44),
      .cin(cin44), .sub(sub44), .out_valid(ov44), .out_ready(or44), .sum(sum44),
      .cout(cout44), .ovf(ovf44));

   // ---------------- scoreboard ----------------
   exp_t q8[$], q41[$], q44[$];
   exp_t e_none;
   logic ov8_p = 0, ov41_p = 0, ov44_p = 0;

   always @(negedge rst8_n) q8.delete();
   always @(negedge rst_n) begin
      q41.delete();
      q44.delete();
   end

   // Record accepted operands and retire handshaked results.
   always @(posedge clk) begin
      if (rst8_n && iv8 && ir8) q8.push_back('{r: model(8, int'(a8), int'(b8), cin8, sub8), cyc: cyc});
      if (rst_n && iv41 && ir41) q41.push_back('{r: model(4, int'(a41), int'(b41), cin41, sub41), cyc: cyc});
      if (rst_n && iv44 && ir44) q44.push_back('{r: model(4, int'(a44), int'(b44), cin44, sub44), cyc: cyc});
      if (rst8_n && ov8 && or8 && q8.size() > 0) void'(q8.pop_front());
      if (rst_n && ov41 && or41 && q41.size() > 0) void'(q41.pop_front());
      if (rst_n && ov44 && or44 && q44.size() > 0) void'(q44.pop_front());
      cyc = cyc + 1;
   end

   task automatic cmp(input string tag, input int n, input int qsize, input exp_t e,
                      input logic [7:0] s, input logic co, input logic ov, input logic first);
      check({tag, "_pending"}, qsize, 1);
      if (qsize > 0) begin
         check({tag, "_sum"}, s, e.r.sum);
         check({tag, "_cout"}, co, e.r.cout);
         check({tag, "_ovf"}, ov, e.r.ovf);
         if (first) check({tag, "_latency"}, cyc - e.cyc - 1, n);
      end
   endtask

   // Compare every valid output cycle against the oldest outstanding operation.
   always @(negedge clk) begin
      exp_t e;
      if (rst8_n && ov8) begin
         e = e_none;
         if (q8.size() > 0) e = q8[0];
         cmp("d8", 4, q8.size(), e, sum8, cout8, ovf8, !ov8_p);
      end
      if (rst_n && ov41) begin
         e = e_none;
         if (q41.size() > 0) e = q41[0];
         cmp("d41", 4, q41.size(), e, {4'b0, sum41}, cout41, ovf41, !ov41_p);
      end
      if (rst_n && ov44) begin
         e = e_none;
         if (q44.size() > 0) e = q44[0];
         cmp("d44", 1, q44.size(), e, {4'b0, sum44}, cout44, ovf44, !ov44_p);
      end
      ov8_p  = ov8;
      ov41_p = ov41;
      ov44_p = ov44;
   end

   // ---------------- directed WIDTH=8 DIGIT=2 ----------------
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                      input logic [7:0] es, input logic ec, input logic eo, input string nm);
      int n;
      @(negedge clk);
      a8 = a; b8 = b; cin8 = cin; sub8 = sub; iv8 = 1'b1;
      n = 0;
      while (!ir8 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({nm, "_accept"}, ir8, 1);
      @(posedge clk);
      #1 iv8 = 1'b0;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!ov8 && n < 50);
      check({nm, "_latency"}, n, 4);
      check({nm, "_sum"}, sum8, es);
      check({nm, "_cout"}, cout8, ec);
      check({nm, "_ovf"}, ovf8, eo);
      if (or8) begin
         @(posedge clk);
         #1;
         check({nm, "_idle_valid"}, ov8, 0);
         check({nm, "_idle_ready"}, ir8, 1);
         check({nm, "_retained_sum"}, sum8, es);
      end
   endtask

   task automatic directed8();
      op8(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, "add_0f_01");
      op8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "add_ovf");
      op8(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "add_carry");
      op8(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_neg");
      op8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_ovf");

      // Backpressure: result held for three cycles while a new operand waits.
      or8 = 1'b0;
      op8(8'h3C, 8'h41, 1'b0, 1'b0, 8'h7D, 1'b0, 1'b0, "bp");
      @(negedge clk);
      a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("bp_hold_valid", ov8, 1);
         check("bp_hold_sum", sum8, 8'h7D);
         check("bp_hold_flags", {cout8, ovf8}, 2'b00);
         check("bp_hold_in_ready", ir8, 0);
      end
      @(negedge clk);
      or8 = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_valid", ov8, 0);
      check("bp_release_ready", ir8, 1);
      op8(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, "bp_next");

      // Reset two cycles into RUN.
      @(negedge clk);
      a8 = 8'h55; b8 = 8'h11; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
      @(posedge clk);
      #1 iv8 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst8_n = 1'b0;
      #1;
      check("rst_run_valid", ov8, 0);
      check("rst_run_ready", ir8, 1);
      check("rst_run_sum", sum8, 8'h00);
      @(negedge clk);
      rst8_n = 1'b1;
      op8(8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, "post_rst");

      // Reset while a result is waiting in DONE.
      or8 = 1'b0;
      op8(8'hAA, 8'h55, 1'b1, 1'b1, 8'h54, 1'b1, 1'b1, "sub_borrow");
      #2 rst8_n = 1'b0;
      #1;
      check("rst_done_valid", ov8, 0);
      check("rst_done_sum", sum8, 8'h00);
      check("rst_done_flags", {cout8, ovf8}, 2'b00);
      @(negedge clk);
      rst8_n = 1'b1;
      or8    = 1'b1;
   endtask

   // ---------------- main ----------------
   initial begin
      repeat (3) @(negedge clk);
      check("reset_in_ready", ir8, 1);
      check("reset_out_valid", ov8, 0);
      check("reset_sum", sum8, 8'h00);
      check("reset_flags", {cout8, ovf8}, 2'b00);
      check("reset_d41", {ir41, ov41, sum41, cout41, ovf41}, 8'b1000_0000);
      check("reset_d44", {ir44, ov44, sum44, cout44, ovf44}, 8'b1000_0000);
      rst8_n = 1'b1;
      rst_n  = 1'b1;

      fork
         directed8();
         begin : exh41
            int n;
            for (int a = 0; a < 16; a++)
               for (int b = 0; b < 16; b++)
                  for (int c = 0; c < 2; c++)
                     for (int s = 0; s < 2; s++) begin
                        @(negedge clk);
                        a41 = 4'(a); b41 = 4'(b); cin41 = 1'(c); sub41 = 1'(s); iv41 = 1'b1;
                        n = 0;
                        while (!ir41 && n < 50) begin
                           @(negedge clk);
                           n++;
                        end
                        if (!ir41) check("d41_accept", ir41, 1);
                        @(posedge clk);
                        #1 iv41 = 1'b0;
                     end
         end
         begin : exh44
            int n;
            for (int a = 0; a < 16; a++)
               for (int b = 0; b < 16; b++)
                  for (int c = 0; c < 2; c++)
                     for (int s = 0; s < 2; s++) begin
                        @(negedge clk);
                        a44 = 4'(a); b44 = 4'(b); cin44 = 1'(c); sub44 = 1'(s); iv44 = 1'b1;
                        n = 0;
                        while (!ir44 && n < 50) begin
                           @(negedge clk);
                           n++;
                        end
                        if (!ir44) check("d44_accept", ir44, 1);
                        @(posedge clk);
                        #1 iv44 = 1'b0;
                     end
         end
      join

      repeat (10) @(negedge clk);
      check("drain_d8", q8.size(), 0);
      check("drain_d41", q41.size(), 0);
      check("drain_d44", q44.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
